// File: rtl/demux_route_pkg.sv
// ============================================================================
// Module   : demux_route_pkg
// Brief    : Shared constants and types for the 4-channel routing demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_route_pkg;

    localparam int NCH       = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 16;
    localparam int STALL_W   = 8;

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef logic [SEL_W-1:0] chan_sel_t;

endpackage : demux_route_pkg

`default_nettype wire

// File: rtl/demux_chan_reg.sv
// ============================================================================
// Module   : demux_chan_reg
// Brief    : One output channel's data/valid holding register (load, ack).
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_chan_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // A load wins over an ack so a refill in the ack cycle leaves no bubble;
    // data is never cleared by an ack.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : demux_chan_reg

`default_nettype wire

// File: rtl/demux_route_4.sv
// ============================================================================
// Module   : demux_route_4
// Brief    : Routes one input word per cycle to one of four held channels.
//            Optional stall counter enabled by DEMUX_ROUTE_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_route_4
    import demux_route_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 E,
    input  logic                 in_valid,
    input  chan_sel_t            in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ack
`ifdef DEMUX_ROUTE_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]   stall_cnt
`endif
);

    logic w_xfer;

    assign in_ready = E & (~out_valid[in_sel] | out_ack[in_sel]);
    assign w_xfer   = in_valid & in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        logic w_load;

        assign w_load = w_xfer & (in_sel == chan_sel_t'(k));

        demux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load_i  (w_load),
            .data_i  (in_data),
            .ack_i   (out_ack[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH]),
            .valid_o (out_valid[k])
        );
    end

`ifdef DEMUX_ROUTE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q;
    logic [STALL_W-1:0] stall_cnt_d;

    // Counts producer stalls caused by a full channel, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && E && !in_ready && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // No stall counter in this build.
`endif

endmodule : demux_route_4

`default_nettype wire
